// File: rtl/axi_lcd_lite_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lcd_lite_slave_if
//  Description : AXI4-Lite bus bundle for the LCD register slave, with
//                master and slave modports.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lcd_lite_slave_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32
);
   // Write address channel
   logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR;
   logic [2:0]                      AWPROT;
   logic                            AWVALID;
   logic                            AWREADY;
   // Write data channel
   logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB;
   logic                            WVALID;
   logic                            WREADY;
   // Write response channel
   logic [1:0]                      BRESP;
   logic                            BVALID;
   logic                            BREADY;
   // Read address channel
   logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR;
   logic [2:0]                      ARPROT;
   logic                            ARVALID;
   logic                            ARREADY;
   // Read data channel
   logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA;
   logic [1:0]                      RRESP;
   logic                            RVALID;
   logic                            RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, input  AWREADY,
      output WDATA, WSTRB, WVALID,    input  WREADY,
      input  BRESP, BVALID,           output BREADY,
      output ARADDR, ARPROT, ARVALID, input  ARREADY,
      input  RDATA, RRESP, RVALID,    output RREADY
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, output AWREADY,
      input  WDATA, WSTRB, WVALID,    output WREADY,
      output BRESP, BVALID,           input  BREADY,
      input  ARADDR, ARPROT, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID,    input  RREADY
   );
endinterface
`default_nettype wire

// File: rtl/axi_lcd_lite_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lcd_lite_slave
//  Description : AXI4-Lite slave holding four 32-bit LCD control registers
//                (offsets 0x0/0x4/0x8/0xC) with per-register write strobes.
//                Optional macro AXI_LCD_SLVERR_EN: accesses with
//                addr[31:4] != 0 get SLVERR; otherwise addresses alias.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lcd_lite_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   axi_lcd_lite_slave_if.slave             s_axi,
   output logic [4*C_S_AXI_DATA_WIDTH-1:0] lcd_regs,
   output logic [3:0]                      lcd_wr_pulse
);
   localparam int         c_NUM_REGS    = 4;
   localparam int         c_STRB_W      = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] c_RESP_OKAY   = 2'b00;
   localparam logic [1:0] c_RESP_SLVERR = 2'b10;

   logic                          r_aw_held;
   logic [C_S_AXI_ADDR_WIDTH-1:0] r_aw_addr;
   logic                          r_w_held;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_w_data;
   logic [c_STRB_W-1:0]           r_w_strb;
   logic                          r_bvalid;
   logic [1:0]                    r_bresp;
   logic                          r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                    r_rresp;
   logic [3:0]                    r_wr_pulse;

   logic                          w_aw_hs;
   logic                          w_w_hs;
   logic                          w_ar_hs;
   logic                          w_commit;
   logic                          w_wr_ok;
   logic                          w_rd_ok;
   logic [1:0]                    w_wr_idx;
   logic [1:0]                    w_rd_idx;
   logic [3:0]                    w_wr_sel;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_word;
   logic                          w_unused;

   // Readies are forced low during reset so nothing is accepted in that cycle
   assign s_axi.AWREADY = !ARESET && !r_aw_held && !r_bvalid;
   assign s_axi.WREADY  = !ARESET && !r_w_held  && !r_bvalid;
   assign s_axi.ARREADY = !ARESET && !r_rvalid;

   assign w_aw_hs  = s_axi.AWVALID && s_axi.AWREADY;
   assign w_w_hs   = s_axi.WVALID  && s_axi.WREADY;
   assign w_ar_hs  = s_axi.ARVALID && s_axi.ARREADY;
   assign w_commit = r_aw_held && r_w_held;
   assign w_wr_idx = r_aw_addr[3:2];
   assign w_rd_idx = s_axi.ARADDR[3:2];

`ifdef AXI_LCD_SLVERR_EN
   assign w_wr_ok  = (r_aw_addr[C_S_AXI_ADDR_WIDTH-1:4] == '0);
   assign w_rd_ok  = (s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:4] == '0);
   assign w_unused = ^{s_axi.AWPROT, s_axi.ARPROT, r_aw_addr[1:0], s_axi.ARADDR[1:0]};
`else
   assign w_wr_ok  = 1'b1;
   assign w_rd_ok  = 1'b1;
   assign w_unused = ^{s_axi.AWPROT, s_axi.ARPROT,
                       r_aw_addr[C_S_AXI_ADDR_WIDTH-1:4], r_aw_addr[1:0],
                       s_axi.ARADDR[C_S_AXI_ADDR_WIDTH-1:4], s_axi.ARADDR[1:0]};
`endif

   // A write only targets a register when it is accepted and enables a byte
   assign w_wr_sel = (w_commit && w_wr_ok && (r_w_strb != '0)) ? (4'b0001 << w_wr_idx) : 4'b0000;

   // Write-address holding register: filled on AW handshake, emptied on commit
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_aw_held <= 1'b0;
         r_aw_addr <= '0;
      end else if (w_aw_hs) begin
         r_aw_held <= 1'b1;
         r_aw_addr <= s_axi.AWADDR;
      end else if (w_commit) begin
         r_aw_held <= 1'b0;
      end
   end

   // Write-data holding register: filled on W handshake, emptied on commit
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_w_held <= 1'b0;
         r_w_data <= '0;
         r_w_strb <= '0;
      end else if (w_w_hs) begin
         r_w_held <= 1'b1;
         r_w_data <= s_axi.WDATA;
         r_w_strb <= s_axi.WSTRB;
      end else if (w_commit) begin
         r_w_held <= 1'b0;
      end
   end

   // Register file: byte-lane merge of the held write data on commit
   generate
      for (genvar gi = 0; gi < c_NUM_REGS; gi++) begin : g_reg
         logic [C_S_AXI_DATA_WIDTH-1:0] r_reg;

         // One register: reset to zero, update enabled byte lanes when selected
         always_ff @(posedge ACLK) begin
            if (ARESET) begin
               r_reg <= '0;
            end else if (w_wr_sel[gi]) begin
               for (int b = 0; b < c_STRB_W; b++) begin
                  if (r_w_strb[b]) begin
                     r_reg[8*b +: 8] <= r_w_data[8*b +: 8];
                  end
               end
            end
         end

         assign lcd_regs[gi*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = r_reg;
      end
   endgenerate

   // Per-register strobe, high in the cycle following the commit edge
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_pulse <= 4'b0000;
      end else begin
         r_wr_pulse <= w_wr_sel;
      end
   end

   // Write response: raised on commit, held until the B handshake
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_bvalid <= 1'b0;
         r_bresp  <= c_RESP_OKAY;
      end else if (w_commit) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
      end else if (r_bvalid && s_axi.BREADY) begin
         r_bvalid <= 1'b0;
      end
   end

   // Read word select; the pre-commit register value is seen on a same-edge write
   always_comb begin
      w_rd_word = '0;
      if (w_rd_ok) begin
         w_rd_word = lcd_regs[w_rd_idx*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH];
      end
   end

   // Read response: captured on AR handshake, held stable until R handshake
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= c_RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_word;
         r_rresp  <= w_rd_ok ? c_RESP_OKAY : c_RESP_SLVERR;
      end else if (r_rvalid && s_axi.RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   assign s_axi.BVALID  = r_bvalid;
   assign s_axi.BRESP   = r_bresp;
   assign s_axi.RVALID  = r_rvalid;
   assign s_axi.RDATA   = r_rdata;
   assign s_axi.RRESP   = r_rresp;
   assign lcd_wr_pulse  = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_axi_lcd_lite_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lcd_lite_slave
//  Description : Self-checking bench for axi_lcd_lite_slave; directed and
//                randomised transfers against a register-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lcd_lite_slave;
`ifdef AXI_LCD_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   logic         tb_ACLK;
   logic         tb_ARESET;
   logic [127:0] lcd_regs;
   logic [3:0]   lcd_wr_pulse;
   int           checks = 0;
   int           errors = 0;
   logic [31:0]  m_regs [4];

   axi_lcd_lite_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) bus ();

   axi_lcd_lite_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32)) dut (
      .ACLK         (tb_ACLK),
      .ARESET       (tb_ARESET),
      .s_axi        (bus),
      .lcd_regs     (lcd_regs),
      .lcd_wr_pulse (lcd_wr_pulse)
   );

   initial tb_ACLK = 1'b0;
   always #5 tb_ACLK = ~tb_ACLK;

   // ---------------- reference model ----------------
   function automatic bit in_range(input logic [31:0] a);
      return (a[31:4] == 28'd0) || !SLVERR_EN;
   endfunction

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                       output logic [1:0] r, output logic [3:0] p);
      int idx;
      idx = int'(a[3:2]);
      r = 2'b00;
      p = 4'b0000;
      if (!in_range(a)) begin
         r = 2'b10;
         return;
      end
      for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
      if (s != 4'b0000) p = 4'b0001 << idx;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [31:0] a);
      return in_range(a) ? m_regs[int'(a[3:2])] : 32'h0;
   endfunction

   function automatic logic [127:0] model_lcd();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
   endfunction

   // ---------------- bus drivers ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output logic [3:0] pulse_or, output int pulse_cyc,
                            output int b_low, output bit rdy_viol, output bit extra_b, output bit tmo);
      bit aw_done, w_done, b_done;
      int cyc, bv_cnt;
      aw_done = 0; w_done = 0; b_done = 0; cyc = 0; bv_cnt = 0;
      resp = 2'b11; pulse_or = 4'b0; pulse_cyc = 0; b_low = 0; rdy_viol = 0; extra_b = 0;
      while (!b_done && cyc < 200) begin
         bus.AWVALID = !aw_done && (cyc >= aw_dly);
         bus.AWADDR  = addr;
         bus.AWPROT  = 3'($urandom);
         bus.WVALID  = !w_done && (cyc >= w_dly);
         bus.WDATA   = data;
         bus.WSTRB   = strb;
         bus.BREADY  = (bv_cnt >= b_dly);
         @(negedge tb_ACLK);
         if (lcd_wr_pulse != 4'b0) pulse_cyc++;
         pulse_or = pulse_or | lcd_wr_pulse;
         if (bus.BVALID && (bus.AWREADY || bus.WREADY)) rdy_viol = 1;
         if (bus.AWVALID && bus.AWREADY) aw_done = 1;
         if (bus.WVALID && bus.WREADY) w_done = 1;
         if (bus.BVALID) begin
            if (bus.BREADY) begin
               resp   = bus.BRESP;
               b_done = 1;
            end else begin
               b_low++;
            end
            bv_cnt++;
         end
         @(posedge tb_ACLK);
         #1;
         cyc++;
      end
      bus.AWVALID = 0; bus.WVALID = 0; bus.BREADY = 0;
      tmo = !b_done;
      @(negedge tb_ACLK);
      if (lcd_wr_pulse != 4'b0) pulse_cyc++;
      pulse_or = pulse_or | lcd_wr_pulse;
      if (bus.BVALID) extra_b = 1;
      @(posedge tb_ACLK);
      #1;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output bit unstable, output bit tmo);
      bit ar_done, r_done;
      int cyc, rv_cnt, ar_cyc;
      logic [31:0] first_d;
      logic [1:0]  first_r;
      ar_done = 0; r_done = 0; cyc = 0; rv_cnt = 0; ar_cyc = 0;
      first_d = 32'h0; first_r = 2'b0;
      data = 32'hxxxx_xxxx; resp = 2'b11; lat = -1; unstable = 0;
      while (!r_done && cyc < 200) begin
         bus.ARVALID = !ar_done && (cyc >= ar_dly);
         bus.ARADDR  = addr;
         bus.ARPROT  = 3'($urandom);
         bus.RREADY  = (rv_cnt >= r_dly);
         @(negedge tb_ACLK);
         if (bus.ARVALID && bus.ARREADY) begin
            ar_done = 1;
            ar_cyc  = cyc;
         end
         if (bus.RVALID) begin
            if (rv_cnt == 0) begin
               first_d = bus.RDATA;
               first_r = bus.RRESP;
               lat     = cyc - ar_cyc;
            end else if (bus.RDATA !== first_d || bus.RRESP !== first_r) begin
               unstable = 1;
            end
            rv_cnt++;
            if (bus.RREADY) begin
               data   = bus.RDATA;
               resp   = bus.RRESP;
               r_done = 1;
            end
         end
         @(posedge tb_ACLK);
         #1;
         cyc++;
      end
      bus.ARVALID = 0; bus.RREADY = 0;
      tmo = !r_done;
   endtask

   task automatic do_reset(input int cycles);
      tb_ARESET = 1'b1;
      repeat (cycles) @(posedge tb_ACLK);
      #1;
      tb_ARESET = 1'b0;
      model_clear();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge tb_ACLK);
      checks++;
      if ({bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000 (awr,wr,arr,bv,rv)",
                  {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID});
      end
      checks++;
      if ({bus.BRESP, bus.RRESP, bus.RDATA} !== 36'h0 || lcd_regs !== 128'h0 || lcd_wr_pulse !== 4'h0) begin
         errors++;
         $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h regs=%h pulse=%b expected all zero",
                  bus.BRESP, bus.RRESP, bus.RDATA, lcd_regs, lcd_wr_pulse);
      end
      @(posedge tb_ACLK);
      #1;
      tb_ARESET = 1'b0;
      model_clear();
      @(negedge tb_ACLK);
      checks++;
      if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
      end
      @(posedge tb_ACLK);
      #1;
   endtask

   task automatic test_basic();
      logic [1:0] r, er; logic [3:0] p, ep; int pc, bl, lat; bit rv, eb, to, un; logic [31:0] d;
      model_write(32'h0, 32'h0101FFFF, 4'hF, er, ep);
      axi_write(32'h0, 32'h0101FFFF, 4'hF, 0, 0, 0, r, p, pc, bl, rv, eb, to);
      checks++;
      if (to || r !== er) begin
         errors++; $display("FAIL basic_bresp: got %b (timeout=%0d) expected %b", r, to, er);
      end
      checks++;
      if (p !== ep || pc != 1) begin
         errors++; $display("FAIL basic_pulse: got %b for %0d cycles expected %b for 1", p, pc, ep);
      end
      axi_read(32'h0, 0, 0, d, r, lat, un, to);
      checks++;
      if (to || d !== model_rdata(32'h0) || r !== 2'b00) begin
         errors++; $display("FAIL basic_read: got %h/%b expected %h/00", d, r, model_rdata(32'h0));
      end
      checks++;
      if (lat != 1) begin
         errors++; $display("FAIL basic_read_latency: got %0d expected 1", lat);
      end
   endtask

   task automatic test_sequential();
      logic [31:0] addrs [3] = '{32'h4, 32'h8, 32'hC};
      logic [31:0] vals  [3] = '{32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
      logic [1:0] r, er; logic [3:0] p, ep; int pc, bl, lat; bit rv, eb, to, un; logic [31:0] d;
      for (int i = 0; i < 3; i++) begin
         model_write(addrs[i], vals[i], 4'hF, er, ep);
         axi_write(addrs[i], vals[i], 4'hF, 0, 0, 0, r, p, pc, bl, rv, eb, to);
         axi_read(addrs[i], 0, 1, d, r, lat, un, to);
         checks++;
         if (to || d !== vals[i] || r !== 2'b00 || un) begin
            errors++;
            $display("FAIL seq_read[%0d]: got %h/%b unstable=%0d expected %h/00", i, d, r, un, vals[i]);
         end
      end
      checks++;
      if (lcd_regs !== model_lcd()) begin
         errors++; $display("FAIL seq_lcd_regs: got %h expected %h", lcd_regs, model_lcd());
      end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] r, er; logic [3:0] p, ep; int pc, bl; bit rv, eb, to;
      model_write(32'h8, 32'h5A5A_1234, 4'hF, er, ep);
      axi_write(32'h8, 32'h5A5A_1234, 4'hF, 3, 0, 5, r, p, pc, bl, rv, eb, to);
      checks++;
      if (to || bl != 5 || eb) begin
         errors++;
         $display("FAIL wfirst_bhold: got %0d low-ready cycles extra=%0d timeout=%0d expected 5/0/0", bl, eb, to);
      end
      checks++;
      if (rv) begin
         errors++; $display("FAIL wfirst_ready_during_b: got 1 expected 0");
      end
      checks++;
      if (r !== er || p !== ep || pc != 1 || lcd_regs !== model_lcd()) begin
         errors++;
         $display("FAIL wfirst_result: got resp=%b pulse=%b x%0d regs=%h expected %b/%b x1/%h",
                  r, p, pc, lcd_regs, er, ep, model_lcd());
      end
   endtask

   task automatic test_strobe();
      logic [1:0] r, er; logic [3:0] p, ep; int pc, bl, lat; bit rv, eb, to, un; logic [31:0] d;
      model_write(32'h4, 32'hABCD0001, 4'hF, er, ep);
      axi_write(32'h4, 32'hABCD0001, 4'hF, 0, 0, 0, r, p, pc, bl, rv, eb, to);
      model_write(32'h4, 32'h12345678, 4'b0101, er, ep);
      axi_write(32'h4, 32'h12345678, 4'b0101, 1, 0, 0, r, p, pc, bl, rv, eb, to);
      axi_read(32'h4, 0, 0, d, r, lat, un, to);
      checks++;
      if (to || d !== model_rdata(32'h4)) begin
         errors++; $display("FAIL strobe_read: got %h expected %h", d, model_rdata(32'h4));
      end
      model_write(32'h4, 32'hFFFFFFFF, 4'b0000, er, ep);
      axi_write(32'h4, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, r, p, pc, bl, rv, eb, to);
      checks++;
      if (to || r !== er || p !== ep || lcd_regs !== model_lcd()) begin
         errors++;
         $display("FAIL strobe_zero: got resp=%b pulse=%b regs=%h expected %b/%b/%h",
                  r, p, lcd_regs, er, ep, model_lcd());
      end
   endtask

   task automatic test_order();
      int awd [3] = '{0, 2, 0};
      int wd  [3] = '{2, 0, 0};
      logic [1:0] r, er; logic [3:0] p, ep; int pc, bl; bit rv, eb, to;
      for (int i = 0; i < 3; i++) begin
         model_write(32'h8, 32'h1111_0000 + i, 4'hF, er, ep);
         axi_write(32'h8, 32'h1111_0000 + i, 4'hF, awd[i], wd[i], 0, r, p, pc, bl, rv, eb, to);
         checks++;
         if (to || eb || r !== er || p !== ep || pc != 1 || lcd_regs !== model_lcd()) begin
            errors++;
            $display("FAIL order[%0d]: got resp=%b pulse=%b x%0d extra=%0d regs=%h expected %b/%b x1/0/%h",
                     i, r, p, pc, eb, lcd_regs, er, ep, model_lcd());
         end
      end
   endtask

   task automatic test_concurrent();
      logic [1:0] r, er, rr; logic [3:0] p, ep; int pc, bl, lat; bit rv, eb, to, to2, un;
      logic [31:0] d, old_val;
      old_val = m_regs[3];
      model_write(32'hC, 32'h7777_8888, 4'hF, er, ep);
      fork
         axi_write(32'hC, 32'h7777_8888, 4'hF, 0, 0, 0, r, p, pc, bl, rv, eb, to);
         axi_read(32'hC, 1, 0, d, rr, lat, un, to2);
      join
      checks++;
      if (to2 || d !== old_val) begin
         errors++; $display("FAIL same_edge_read: got %h expected pre-write %h", d, old_val);
      end
      checks++;
      if (to || lcd_regs !== model_lcd()) begin
         errors++; $display("FAIL same_edge_write: got %h expected %h", lcd_regs, model_lcd());
      end
   endtask

   task automatic test_range();
      logic [1:0] r, er; logic [3:0] p, ep; int pc, bl, lat; bit rv, eb, to, un; logic [31:0] d;
      model_write(32'h0, 32'h1111_2222, 4'hF, er, ep);
      axi_write(32'h0, 32'h1111_2222, 4'hF, 0, 0, 0, r, p, pc, bl, rv, eb, to);
      model_write(32'h10, 32'hCAFE_F00D, 4'hF, er, ep);
      axi_write(32'h10, 32'hCAFE_F00D, 4'hF, 0, 0, 0, r, p, pc, bl, rv, eb, to);
      checks++;
      if (to || r !== er || p !== ep || lcd_regs !== model_lcd()) begin
         errors++;
         $display("FAIL range_write: got resp=%b pulse=%b regs=%h expected %b/%b/%h",
                  r, p, lcd_regs, er, ep, model_lcd());
      end
      axi_read(32'h10, 0, 0, d, r, lat, un, to);
      checks++;
      if (to || d !== model_rdata(32'h10) || r !== (in_range(32'h10) ? 2'b00 : 2'b10)) begin
         errors++;
         $display("FAIL range_read: got %h/%b expected %h/%b", d, r, model_rdata(32'h10),
                  in_range(32'h10) ? 2'b00 : 2'b10);
      end
   endtask

   task automatic test_reset_mid();
      // Hold an AW and leave a read response pending, then reset
      bus.AWVALID = 1; bus.AWADDR = 32'h4; bus.AWPROT = 3'b0;
      bus.ARVALID = 1; bus.ARADDR = 32'h0; bus.ARPROT = 3'b0; bus.RREADY = 0;
      @(posedge tb_ACLK);
      #1;
      bus.AWVALID = 0; bus.ARVALID = 0;
      tb_ARESET = 1'b1;
      @(negedge tb_ACLK);
      checks++;
      if (bus.BVALID !== 1'b0 || bus.RVALID !== 1'b1) begin
         errors++; $display("FAIL midreset_pre: got bvalid=%b rvalid=%b expected 0/1", bus.BVALID, bus.RVALID);
      end
      @(posedge tb_ACLK);
      #1;
      tb_ARESET = 1'b0;
      model_clear();
      @(negedge tb_ACLK);
      checks++;
      if (bus.RVALID !== 1'b0 || bus.RDATA !== 32'h0 || lcd_regs !== model_lcd() ||
          {bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
         errors++;
         $display("FAIL midreset_post: got rvalid=%b rdata=%h regs=%h rdy=%b expected 0/0/0/111",
                  bus.RVALID, bus.RDATA, lcd_regs, {bus.AWREADY, bus.WREADY, bus.ARREADY});
      end
      // A lone W must not pair with the discarded AW
      @(posedge tb_ACLK);
      #1;
      bus.WVALID = 1; bus.WDATA = 32'hFFFF_FFFF; bus.WSTRB = 4'hF;
      @(posedge tb_ACLK);
      #1;
      bus.WVALID = 0;
      repeat (3) @(posedge tb_ACLK);
      @(negedge tb_ACLK);
      checks++;
      if (bus.BVALID !== 1'b0 || lcd_regs !== model_lcd()) begin
         errors++; $display("FAIL midreset_nocommit: got bvalid=%b regs=%h expected 0/0", bus.BVALID, lcd_regs);
      end
      @(posedge tb_ACLK);
      #1;
      do_reset(2);
   endtask

   task automatic test_random();
      logic [1:0] r, er; logic [3:0] p, ep; int pc, bl, lat; bit rv, eb, to, un;
      logic [31:0] a, d, rd; logic [3:0] s;
      for (int i = 0; i < 40; i++) begin
         a = {($urandom_range(0, 5) == 0) ? 28'($urandom) : 28'd0, 4'($urandom)};
         d = $urandom;
         s = 4'($urandom);
         model_write(a, d, s, er, ep);
         axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   r, p, pc, bl, rv, eb, to);
         checks++;
         if (to || eb || rv || r !== er || p !== ep || pc != ((ep != 4'b0) ? 1 : 0) || lcd_regs !== model_lcd()) begin
            errors++;
            $display("FAIL rand_write[%0d] a=%h: got resp=%b pulse=%b x%0d regs=%h expected %b/%b/%h",
                     i, a, r, p, pc, lcd_regs, er, ep, model_lcd());
         end
         a = {($urandom_range(0, 5) == 0) ? 28'($urandom) : 28'd0, 4'($urandom)};
         axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3), rd, r, lat, un, to);
         checks++;
         if (to || un || lat != 1 || rd !== model_rdata(a) || r !== (in_range(a) ? 2'b00 : 2'b10)) begin
            errors++;
            $display("FAIL rand_read[%0d] a=%h: got %h/%b lat=%0d unstable=%0d expected %h/%b",
                     i, a, rd, r, lat, un, model_rdata(a), in_range(a) ? 2'b00 : 2'b10);
         end
      end
   endtask

   initial begin
      tb_ARESET   = 1'b1;
      bus.AWADDR  = 32'h0; bus.AWPROT = 3'b0; bus.AWVALID = 1'b0;
      bus.WDATA   = 32'h0; bus.WSTRB  = 4'h0; bus.WVALID  = 1'b0; bus.BREADY = 1'b0;
      bus.ARADDR  = 32'h0; bus.ARPROT = 3'b0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
      model_clear();
      repeat (3) @(posedge tb_ACLK);
      #1;
      test_reset();
      test_basic();
      test_sequential();
      test_w_before_aw();
      test_strobe();
      test_order();
      test_concurrent();
      test_range();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
